cdc_bus_capture: RTL
====================

Name: cdc_bus_capture

Overview:
- Destination-domain stage directly downstream of the single-bit cdc_sync.
- Takes the synchronised request toggle (req_sync, the cdc_sync output) plus a multi-bit bus that the source domain holds static while its request is pending.
- Waits a settle interval, then captures the bus, emits a one-cycle valid strobe and flips an ack toggle. The ack toggle returns to the source through another cdc_sync.
- Used for control words and frequency words crossing from the Ethernet/PHY clock into the radio clock.

Parameters:
- WIDTH, 32, width of data_a/data_b.
- SETTLE, 2, destination clocks from request-edge detection to capture. Range 1..15; values outside that range are a configuration error.

Ports:
- clkb  in  1  destination-domain clock; all logic on rising edge
- rstb  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion already synchronised to clkb upstream
- req_sync  in  1  request toggle, already double-registered by cdc_sync
- data_a  in  WIDTH  source-domain bus, static from source toggle until ack seen at source
- clear_ovr  in  1  synchronous clear for the overrun flag
- data_b  out  WIDTH  captured word, held until next capture
- valid_b  out  1  one-cycle strobe, high in the cycle data_b first shows a new word
- ack_tgl  out  1  acknowledge toggle, flips once per capture
- busy  out  1  high in SETTLE and CAPTURE states
- overrun  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rstb=0, async):
  - state=INIT; data_b=0; valid_b=0; ack_tgl=0; overrun=0; busy=0; req_last=0; settle counter=0.
- INIT: first edge after reset release loads req_last<=req_sync, goes to IDLE, no capture.
  - A toggle level left over from before reset is never treated as a request.
- IDLE: on any edge where req_sync != req_last: state<=SETTLE, cnt<=1, busy<=1.
- SETTLE:
  - if req_sync == req_last (source toggled twice without waiting for ack): overrun<=1, state<=IDLE, busy<=0. No capture, no ack.
  - else if cnt==SETTLE: state<=CAPTURE.
  - else cnt<=cnt+1.
- CAPTURE (one edge):
  - data_b<=data_a; valid_b<=1; ack_tgl<=~ack_tgl; req_last<=req_sync; state<=IDLE; busy<=0.
- valid_b is high for exactly one clock; it clears on the next edge regardless of state.
- Latency: the edge that detects the mismatch is E0. data_b/valid_b/ack_tgl update at edge E0+SETTLE+1.
- Back-to-back: IDLE may detect a new mismatch on the edge immediately after CAPTURE. Minimum spacing between valid_b strobes is SETTLE+2 clocks.
- overrun is set only in SETTLE.
  - clear_ovr=1 clears it on the next edge.
  - If set and clear happen on the same edge, set wins.
- data_b never changes except in CAPTURE.
- No arithmetic on data; counter width 4 bits, no wrap because SETTLE<=15.
- Reset mid-SETTLE or mid-CAPTURE aborts: no valid_b, ack_tgl=0, re-enters INIT.
  - The source is expected to resynchronise its own toggle on system reset.

Test Plan (WIDTH=8, SETTLE=2):
- Reset release with req_sync=1 held -> INIT absorbs it; no valid_b for 20 clocks; ack_tgl=0; overrun=0.
- Basic capture: data_a=0xA5, req_sync 0->1 detected at E0 -> busy=1 at E0..E2. At E3, data_b=0xA5, valid_b=1 for one cycle, ack_tgl=1.
- Back-to-back: second toggle (1->0, data_a=0x3C) present on the edge after capture -> second valid_b exactly 4 clocks after the first, data_b=0x3C, ack_tgl=0.
- Overrun: req_sync toggles 0->1 then 1->0 one clock later -> overrun=1, no valid_b, ack_tgl unchanged. Then clear_ovr pulse -> overrun=0 next edge. Clear coincident with a new violation -> overrun stays 1.
- Reset mid-SETTLE: assert rstb=0 one clock after detection -> outputs immediately 0. No valid_b after release; INIT reloads req_last.
- Data stability: data_a changes during SETTLE then holds 0x5A from the capture edge -> data_b=0x5A. data_b holds 0x5A unchanged while data_a toggles in IDLE.

Source files
------------

// File: rtl/cdc_bus_capture_if.sv
// Bus bundle between a source-domain holder and the destination-side capture stage.
// The master drives the request toggle, held word and overrun clear; the slave returns the capture results.
interface cdc_bus_capture_if #(
  parameter int WIDTH = 32
);
  logic             req_sync;
  logic [WIDTH-1:0] data_a;
  logic             clear_ovr;
  logic [WIDTH-1:0] data_b;
  logic             valid_b;
  logic             ack_tgl;
  logic             busy;
  logic             overrun;

  modport master (
    output req_sync, data_a, clear_ovr,
    input  data_b, valid_b, ack_tgl, busy, overrun
  );

  modport slave (
    input  req_sync, data_a, clear_ovr,
    output data_b, valid_b, ack_tgl, busy, overrun
  );
endinterface

// File: rtl/cdc_bus_capture.sv
// Destination-side toggle-handshake capture: detects a synchronised request edge,
// waits SETTLE clocks for the static bus to settle, then latches it and flips the ack toggle.
module cdc_bus_capture #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 2
) (
  input  logic            clkb,
  input  logic            rstb,
  cdc_bus_capture_if.slave bus
);

  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("cdc_bus_capture: SETTLE must lie in 1..15");
    end
  endgenerate

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic             req_last_reg, req_last_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             ack_reg, ack_next;
  logic             busy_reg, busy_next;
  logic             ovr_reg, ovr_next;

  always_ff @(posedge clkb or negedge rstb) begin
    if (!rstb) begin
      state_reg    <= ST_INIT;
      cnt_reg      <= '0;
      req_last_reg <= 1'b0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      ack_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      ovr_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      req_last_reg <= req_last_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      ack_reg      <= ack_next;
      busy_reg     <= busy_next;
      ovr_reg      <= ovr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    req_last_next = req_last_reg;
    data_next     = data_reg;
    valid_next    = 1'b0;
    ack_next      = ack_reg;
    busy_next     = busy_reg;
    // A clear is overridden below when a violation lands on the same edge
    ovr_next      = ovr_reg & ~bus.clear_ovr;

    case (state_reg)
      ST_INIT: begin
        // Absorb whatever toggle level survived reset so it is never taken as a request
        req_last_next = bus.req_sync;
        state_next    = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.req_sync != req_last_reg) begin
          state_next = ST_SETTLE;
          cnt_next   = 4'd1;
          busy_next  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (bus.req_sync == req_last_reg) begin
          ovr_next   = 1'b1;
          state_next = ST_IDLE;
          busy_next  = 1'b0;
        end else if (cnt_reg == SETTLE_CNT) begin
          state_next = ST_CAPTURE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      ST_CAPTURE: begin
        data_next     = bus.data_a;
        valid_next    = 1'b1;
        ack_next      = ~ack_reg;
        req_last_next = bus.req_sync;
        state_next    = ST_IDLE;
        busy_next     = 1'b0;
      end
      default: begin
        state_next = ST_INIT;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign bus.data_b  = data_reg;
  assign bus.valid_b = valid_reg;
  assign bus.ack_tgl = ack_reg;
  assign bus.busy    = busy_reg;
  assign bus.overrun = ovr_reg;

endmodule
